// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - request/result bundle for the bit-serial subtractor
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, ovf
  );
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b - bin, LSB first, one full-subtractor cell
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_subtractor_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PENULT = CW'((WIDTH > 1) ? WIDTH - 2 : 0);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic             br;
  logic             msb_br;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             ovf_q;
  logic             busy_c;
  logic             done_c;

  logic             a0;
  logic             b0;
  logic             d;
  logic             br_nx;
  logic [WIDTH:0]   r_cat;
  logic [WIDTH-1:0] r_nx;

  always_comb begin
    a0    = a_sh[0];
    b0    = b_sh[0];
    d     = a0 ^ b0 ^ br;
    br_nx = (~a0 & b0) | (~(a0 ^ b0) & br);
    r_cat = {d, r_sh};
    r_nx  = r_cat[WIDTH:1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy_c   = 1'b0;
    done_c   = 1'b0;
    case (state)
      IDLE: if (bus.start) state_nx = RUN;
      RUN: begin
        busy_c = 1'b1;
        if (cnt == LAST) state_nx = DONE;
      end
      DONE: begin
        done_c   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // msb_br tracks the borrow into the MSB; for WIDTH=1 that is bin itself
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      r_sh   <= '0;
      br     <= 1'b0;
      msb_br <= 1'b0;
      cnt    <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (state == IDLE) begin
      if (bus.start) begin
        a_sh   <= bus.a;
        b_sh   <= bus.b;
        br     <= bus.bin;
        msb_br <= bus.bin;
        cnt    <= '0;
      end
    end else if (state == RUN) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      r_sh <= r_nx;
      br   <= br_nx;
      cnt  <= cnt + 1'b1;
      if (WIDTH > 1 && cnt == PENULT) msb_br <= br_nx;
      if (cnt == LAST) begin
        diff_q <= r_nx;
        bout_q <= br_nx;
        ovf_q  <= msb_br ^ br_nx;
      end
    end
  end

  assign bus.busy = busy_c;
  assign bus.done = done_c;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - randomized and directed checks against an arithmetic model
module tb_serial_subtractor;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_subtractor_if #(.WIDTH(W)) bus8();
  serial_subtractor_if #(.WIDTH(1)) bus1();

  serial_subtractor #(.WIDTH(W)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  serial_subtractor #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // returns {ovf, bout, diff[15:0]} from signed/unsigned integer arithmetic
  function automatic logic [31:0] ref_sub(input int w, input int unsigned a, input int unsigned b,
                                          input int unsigned bin);
    longint m, ud, sa, sb, sd, dm;
    logic bo, ov;
    m  = longint'(1) << w;
    ud = longint'(a) - longint'(b) - longint'(bin);
    bo = (ud < 0);
    dm = ((ud % m) + m) % m;
    sa = (longint'(a) >= m / 2) ? longint'(a) - m : longint'(a);
    sb = (longint'(b) >= m / 2) ? longint'(b) - m : longint'(b);
    sd = sa - sb - longint'(bin);
    ov = (sd < -(m / 2)) || (sd >= m / 2);
    return {14'd0, ov, bo, dm[15:0]};
  endfunction

  // mode 1 re-pulses start with other operands during RUN and during DONE
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                     input int mode, input string tag);
    logic [31:0] e;
    int busy_n, k, extra;
    bit seen;
    e = ref_sub(8, a, b, bin);
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = a; bus8.b = b; bus8.bin = bin;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.bin = 1'($urandom);
    busy_n = 0; seen = 0;
    for (k = 1; k <= 30 && !seen; k++) begin
      @(negedge clk);
      if (bus8.done) begin
        seen = 1;
        chk({tag, ".lat"}, k, 9);
        chk({tag, ".busy_in_done"}, bus8.busy, 0);
        chk({tag, ".diff"}, bus8.diff, e[7:0]);
        chk({tag, ".bout"}, bus8.bout, e[16]);
        chk({tag, ".ovf"}, bus8.ovf, e[17]);
      end else if (bus8.busy) begin
        busy_n++;
      end
      if (mode == 1 && (k == 3 || seen)) begin
        bus8.start = 1'b1; bus8.a = ~a; bus8.b = b ^ 8'h5A; bus8.bin = ~bin;
        @(posedge clk); #1;
        bus8.start = 1'b0;
      end
    end
    chk({tag, ".done_seen"}, seen, 1);
    chk({tag, ".busy_len"}, busy_n, 8);
    extra = 0;
    for (k = 0; k < 15; k++) begin
      @(negedge clk);
      if (bus8.done) extra++;
    end
    chk({tag, ".extra_done"}, extra, 0);
    chk({tag, ".diff_hold"}, bus8.diff, e[7:0]);
  endtask

  initial begin
    logic [31:0] e;
    int prev, k, extra, i;
    bit seen;
    rst_n = 1'b0;
    bus8.start = 0; bus8.a = 0; bus8.b = 0; bus8.bin = 0;
    bus1.start = 0; bus1.a = 0; bus1.b = 0; bus1.bin = 0;
    repeat (3) @(negedge clk);
    chk("rst.busy", bus8.busy, 0);
    chk("rst.done", bus8.done, 0);
    chk("rst.diff", bus8.diff, 0);
    chk("rst.bout_ovf", {bus8.bout, bus8.ovf}, 0);
    rst_n = 1'b1;

    op8(8'h5A, 8'h3C, 1'b0, 0, "d5a3c");
    op8(8'h00, 8'h01, 1'b0, 0, "d0001");
    op8(8'h00, 8'h00, 1'b1, 0, "d00b1");
    op8(8'h80, 8'h01, 1'b0, 0, "d8001");
    op8(8'h7F, 8'hFF, 1'b0, 0, "d7fff");
    op8(8'hC3, 8'h29, 1'b1, 1, "ignore");

    // reset in the middle of RUN
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'h11; bus8.b = 8'h22; bus8.bin = 1'b0;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort.busy_before", bus8.busy, 1);
    rst_n = 1'b0; #1;
    chk("abort.busy", bus8.busy, 0);
    chk("abort.done", bus8.done, 0);
    chk("abort.diff", bus8.diff, 0);
    chk("abort.bout_ovf", {bus8.bout, bus8.ovf}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    for (k = 0; k < 15; k++) begin
      @(negedge clk);
      if (bus8.done) extra++;
    end
    chk("abort.no_done", extra, 0);
    op8(8'h34, 8'h12, 1'b1, 0, "post_abort");

    // back-to-back random operations with start held high
    @(negedge clk);
    bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.bin = 1'($urandom);
    e = ref_sub(8, bus8.a, bus8.b, bus8.bin);
    bus8.start = 1'b1;
    prev = -1;
    for (i = 0; i < 100; i++) begin
      seen = 0;
      for (k = 0; k < 20 && !seen; k++) begin
        @(negedge clk);
        if (bus8.done) seen = 1;
      end
      if (!seen) begin
        chk("b2b.timeout", 0, 1);
        break;
      end
      chk("b2b.diff", bus8.diff, e[7:0]);
      chk("b2b.bout_ovf", {bus8.bout, bus8.ovf}, {e[16], e[17]});
      if (prev >= 0) chk("b2b.spacing", cyc - prev, W + 2);
      prev = cyc;
      bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.bin = 1'($urandom);
      e = ref_sub(8, bus8.a, bus8.b, bus8.bin);
    end
    bus8.start = 1'b0;

    // WIDTH=1 exhaustive, start held high
    @(negedge clk);
    bus1.a = 1'b0; bus1.b = 1'b0; bus1.bin = 1'b0;
    e = ref_sub(1, 0, 0, 0);
    bus1.start = 1'b1;
    prev = -1;
    for (i = 0; i < 8; i++) begin
      seen = 0;
      for (k = 0; k < 10 && !seen; k++) begin
        @(negedge clk);
        if (bus1.done) seen = 1;
      end
      if (!seen) begin
        chk("w1.timeout", 0, 1);
        break;
      end
      chk($sformatf("w1.%0d.diff", i), bus1.diff, e[0]);
      chk($sformatf("w1.%0d.bout", i), bus1.bout, e[16]);
      chk($sformatf("w1.%0d.ovf", i), bus1.ovf, e[17]);
      if (prev >= 0) chk("w1.spacing", cyc - prev, 3);
      prev = cyc;
      if (i < 7) begin
        bus1.a = 1'((i + 1) & 1); bus1.b = 1'(((i + 1) >> 1) & 1); bus1.bin = 1'(((i + 1) >> 2) & 1);
        e = ref_sub(1, (i + 1) & 1, ((i + 1) >> 1) & 1, ((i + 1) >> 2) & 1);
      end
    end
    bus1.start = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
